// File: rtl/pe_array_if.sv
// Stream bundle between the layer sequencer and pe_array: weight beats, broadcast input samples
// and the result vector, each on its own valid/ready pair.
interface pe_array_if #(
    parameter int LANES        = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int PE_OUT_WIDTH = 8
);
    logic                            w_valid;
    logic                            w_ready;
    logic [LANES*WEIGHT_WIDTH-1:0]   w_data;
    logic                            x_valid;
    logic                            x_ready;
    logic [INPUT_WIDTH-1:0]          x_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES*PE_OUT_WIDTH-1:0]   out_data;

    modport master (
        output w_valid, w_data, x_valid, x_data, out_ready,
        input  w_ready, x_ready, out_valid, out_data
    );

    modport slave (
        input  w_valid, w_data, x_valid, x_data, out_ready,
        output w_ready, x_ready, out_valid, out_data
    );
endinterface

// File: rtl/pe_array.sv
// pe_array: LANES MAC neurons over one broadcast input stream, ping-pong weight banks, ReLU and a
// saturating requantizer per lane. Define PE_ARRAY_BIAS_EN for a per-lane bias beat after each bank's weights.

module pe_lane #(
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int INPUT_NUM    = 16,
    parameter int PE_OUT_WIDTH = 8,
    parameter int ACC_W        = 20,
    parameter int SHIFT        = 4,
    parameter int KW           = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
`ifdef PE_ARRAY_BIAS_EN
    input  logic                           bias_en,
`endif
    input  logic                           wr_bank,
    input  logic [KW-1:0]                  wr_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] wr_data,
    input  logic                           acc_clr,
    input  logic                           acc_en,
    input  logic                           rd_bank,
    input  logic [KW-1:0]                  rd_addr,
    input  logic signed [INPUT_WIDTH-1:0]  x,
    output logic [PE_OUT_WIDTH-1:0]        q
);
    localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam logic [ACC_W-1:0] OMAX = ACC_W'((64'd1 << PE_OUT_WIDTH) - 64'd1);

    logic signed [WEIGHT_WIDTH-1:0] wmem [2][INPUT_NUM];
    logic signed [PW-1:0]           prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [ACC_W-1:0]        acc_init;
    logic        [ACC_W-1:0]        shifted;

    always_ff @(posedge clk) begin
        if (wr_en) wmem[wr_bank][wr_addr] <= wr_data;
    end

`ifdef PE_ARRAY_BIAS_EN
    logic signed [WEIGHT_WIDTH-1:0] bias [2];

    always_ff @(posedge clk) begin
        if (bias_en) bias[wr_bank] <= wr_data;
    end

    assign acc_init = {{(ACC_W-WEIGHT_WIDTH){bias[rd_bank][WEIGHT_WIDTH-1]}}, bias[rd_bank]};
`else
    assign acc_init = '0;
`endif

    assign prod     = x * wmem[rd_bank][rd_addr];
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign acc_next = acc + (acc_en ? prod_ext : '0);

    always_ff @(posedge clk) begin
        if (reset)        acc <= '0;
        else if (acc_clr) acc <= acc_init;
        else if (acc_en)  acc <= acc_next;
    end

    // ReLU, truncating shift to the output fraction, then clamp to the unsigned output range
    always_comb begin
        shifted = '0;
        q       = '0;
        if (!acc_next[ACC_W-1]) shifted = $unsigned(acc_next) >> SHIFT;
        if (shifted > OMAX) q = '1;
        else                q = shifted[PE_OUT_WIDTH-1:0];
    end
endmodule

module pe_array #(
    parameter int LANES            = 4,
    parameter int INPUT_WIDTH      = 8,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int INPUT_NUM        = 16,
    parameter int PE_OUT_WIDTH     = 8,
    parameter int FRACTION_IN_BIT  = 8,
    parameter int FRACTION_OUT_BIT = 4
) (
    input logic       clk,
    input logic       reset,
    pe_array_if.slave bus
);
`ifdef PE_ARRAY_BIAS_EN
    localparam int BIAS_B = 1;
`else
    localparam int BIAS_B = 0;
`endif
    localparam int ACC_W      = INPUT_WIDTH + WEIGHT_WIDTH + $clog2(INPUT_NUM) + BIAS_B;
    localparam int LOAD_BEATS = INPUT_NUM + BIAS_B;
    localparam int KW         = $clog2(INPUT_NUM);
    localparam int LW         = $clog2(LOAD_BEATS);
    localparam int SHIFT      = FRACTION_IN_BIT - FRACTION_OUT_BIT;
    localparam logic [LW-1:0] LD_LAST = LW'(LOAD_BEATS - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(INPUT_NUM - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t  state, state_nxt;
    logic [1:0] full;
    logic    fill_ptr, compute_ptr;
    logic [LW-1:0] ld_cnt;
    logic [KW-1:0] k;
    logic    w_fire, x_fire, out_fire, ld_last, k_last;
    logic    acc_clr, acc_en, release_bank, x_rdy;
    logic    wr_w;
`ifdef PE_ARRAY_BIAS_EN
    logic    wr_b;
`endif

    logic [LANES-1:0][WEIGHT_WIDTH-1:0] w_lanes;
    logic [LANES-1:0][PE_OUT_WIDTH-1:0] lane_q;
    logic [LANES-1:0][PE_OUT_WIDTH-1:0] out_q;

    assign w_lanes = bus.w_data;

    // Ready flags come only from registered state, so a bank freed this cycle loads next cycle
    assign bus.w_ready   = !full[fill_ptr];
    assign bus.x_ready   = x_rdy;
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = out_q;

    assign w_fire   = bus.w_valid && bus.w_ready;
    assign x_fire   = bus.x_valid && x_rdy;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign ld_last  = (ld_cnt == LD_LAST);
    assign k_last   = (k == K_LAST);

`ifdef PE_ARRAY_BIAS_EN
    assign wr_w = w_fire && !ld_last;
    assign wr_b = w_fire && ld_last;
`else
    assign wr_w = w_fire;
`endif

    always_comb begin
        state_nxt    = state;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        x_rdy        = 1'b0;
        release_bank = 1'b0;
        case (state)
            IDLE: begin
                if (full[compute_ptr]) begin
                    state_nxt = ACCUM;
                    acc_clr   = 1'b1;
                end
            end
            ACCUM: begin
                x_rdy = 1'b1;
                if (x_fire) begin
                    acc_en = 1'b1;
                    if (k_last) begin
                        release_bank = 1'b1;
                        state_nxt    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // compute_ptr already points at the other bank here
                if (out_fire) begin
                    if (full[compute_ptr]) begin
                        state_nxt = ACCUM;
                        acc_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            full        <= '0;
            fill_ptr    <= 1'b0;
            compute_ptr <= 1'b0;
            ld_cnt      <= '0;
            k           <= '0;
            out_q       <= '0;
        end else begin
            state <= state_nxt;
            if (w_fire) begin
                if (ld_last) begin
                    full[fill_ptr] <= 1'b1;
                    fill_ptr       <= ~fill_ptr;
                    ld_cnt         <= '0;
                end else begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
            end
            if (x_fire) k <= k_last ? '0 : k + 1'b1;
            if (release_bank) begin
                full[compute_ptr] <= 1'b0;
                compute_ptr       <= ~compute_ptr;
                out_q             <= lane_q;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .INPUT_NUM   (INPUT_NUM),
            .PE_OUT_WIDTH(PE_OUT_WIDTH),
            .ACC_W       (ACC_W),
            .SHIFT       (SHIFT),
            .KW          (KW)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_w),
`ifdef PE_ARRAY_BIAS_EN
            .bias_en (wr_b),
`endif
            .wr_bank (fill_ptr),
            .wr_addr (ld_cnt[KW-1:0]),
            .wr_data ($signed(w_lanes[i])),
            .acc_clr (acc_clr),
            .acc_en  (acc_en),
            .rd_bank (compute_ptr),
            .rd_addr (k),
            .x       ($signed(bus.x_data)),
            .q       (lane_q[i])
        );
    end
endmodule

// File: tb/tb_pe_array.sv
// Bench for pe_array: directed golden cases plus randomized weights/inputs checked against a
// dot-product / ReLU / shift / clamp model computed with plain integer arithmetic.
module tb_pe_array;
    localparam int LANES = 4, IW = 8, WW = 8, N = 16, OW = 8, FIN = 8, FOUT = 4;
    localparam int SHIFT = FIN - FOUT;
    localparam int OMAX  = (1 << OW) - 1;
`ifdef PE_ARRAY_BIAS_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pe_array_if #(.LANES(LANES), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .PE_OUT_WIDTH(OW)) bus();

    pe_array #(
        .LANES(LANES), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .INPUT_NUM(N),
        .PE_OUT_WIDTH(OW), .FRACTION_IN_BIT(FIN), .FRACTION_OUT_BIT(FOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wts  [2][LANES][N];
    int bias [2][LANES];
    int xs   [N];

    function automatic logic [LANES*OW-1:0] model(input int sel);
        logic [LANES*OW-1:0] r;
        longint s;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            s = bias[sel][l];
            for (int j = 0; j < N; j++) s += longint'(xs[j]) * longint'(wts[sel][l][j]);
            if (s < 0) s = 0;
            s = s / (64'sd1 << SHIFT);
            if (s > OMAX) s = OMAX;
            r[l*OW +: OW] = OW'(s);
        end
        return r;
    endfunction

    function automatic int srand(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic fill_const(input int sel, input int lane, input int w);
        for (int j = 0; j < N; j++) wts[sel][lane][j] = w;
        bias[sel][lane] = 0;
    endtask

    task automatic fill_random(input int sel);
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < N; j++) wts[sel][l][j] = srand(-128, 127);
`ifdef PE_ARRAY_BIAS_EN
            bias[sel][l] = srand(-128, 127);
`else
            bias[sel][l] = 0;
`endif
        end
    endtask

    task automatic xs_random();
        for (int j = 0; j < N; j++) xs[j] = srand(-128, 127);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.x_valid = 1'b0; bus.x_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_bank(input int sel);
        int t;
        for (int b = 0; b < NB; b++) begin
            bus.w_valid = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                if (b < N) bus.w_data[l*WW +: WW] = WW'(wts[sel][l][b]);
                else       bus.w_data[l*WW +: WW] = WW'(bias[sel][l]);
            end
            t = 0;
            @(negedge clk);
            while (!bus.w_ready && t < BUDGET) begin t++; @(negedge clk); end
            if (!bus.w_ready) begin
                n_cmp++; n_err++;
                $display("FAIL w_ready_timeout: beat %0d of bank %0d never accepted", b, sel);
                bus.w_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic send_x(input int n, input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.x_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            bus.x_valid = 1'b1;
            bus.x_data  = IW'(xs[i]);
            t = 0;
            @(negedge clk);
            while (!bus.x_ready && t < BUDGET) begin t++; @(negedge clk); end
            if (!bus.x_ready) begin
                n_cmp++; n_err++;
                $display("FAIL x_ready_timeout: sample %0d never accepted", i);
                bus.x_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [LANES*OW-1:0] expv);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < BUDGET) begin t++; @(negedge clk); end
        n_cmp++;
        if (!bus.out_valid) begin
            n_err++;
            $display("FAIL %s_timeout: out_valid never rose", name);
            return;
        end
        if (bus.out_data !== expv) begin
            n_err++;
            $display("FAIL %s: out_data got %h want %h", name, bus.out_data, expv);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_latency(input string name);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_latency: out_valid got %b want 1 one cycle after last x", name, bus.out_valid);
        end
    endtask

    task automatic run_case(input string name, input int sel, input bit gaps, input logic [LANES*OW-1:0] expv);
        load_bank(sel);
        send_x(N, gaps);
        check_latency(name);
        get_result(name, expv);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp += 4;
        if (bus.w_ready !== 1'b1)   begin n_err++; $display("FAIL reset_w_ready: got %b want 1", bus.w_ready); end
        if (bus.x_ready !== 1'b0)   begin n_err++; $display("FAIL reset_x_ready: got %b want 0", bus.x_ready); end
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== '0)    begin n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_ones();
        for (int l = 0; l < LANES; l++) fill_const(0, l, 1);
        for (int j = 0; j < N; j++) xs[j] = 16;
        run_case("ones", 0, 1'b0, {LANES{8'd16}});
    endtask

    task automatic test_relu();
        fill_const(1, 0, -1);
        fill_const(1, 1, 2);
        fill_const(1, 2, 3);
        fill_const(1, 3, 0);
        for (int j = 0; j < N; j++) xs[j] = 8;
        run_case("relu", 1, 1'b0, {8'd0, 8'd24, 8'd16, 8'd0});
    endtask

    task automatic test_saturate();
        for (int l = 0; l < LANES; l++) fill_const(0, l, 127);
        for (int j = 0; j < N; j++) xs[j] = 127;
        run_case("saturate", 0, 1'b0, {LANES{8'd255}});
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            fill_random(it % 2);
            xs_random();
            run_case("random", it % 2, bit'(it % 2), model(it % 2));
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*OW-1:0] exp_a, exp_b;
        int stable_err = 0;
        do_reset();
        fill_random(0);
        fill_random(1);
        xs_random();
        exp_a = model(0);
        load_bank(0);
        load_bank(1);
        n_cmp++;
        if (bus.w_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_full_w_ready: got %b want 0 with both banks loaded", bus.w_ready);
        end
        send_x(N, 1'b1);
        check_latency("b2b");
        n_cmp++;
        if (bus.w_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_release_w_ready: got %b want 1 after bank release", bus.w_ready);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.out_data !== exp_a || bus.x_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_err++; stable_err++;
                $display("FAIL b2b_hold: cycle %0d data %h want %h x_ready %b want 0 out_valid %b want 1",
                         c, bus.out_data, exp_a, bus.x_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.x_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_chain: x_ready %b want 1 out_valid %b want 0", bus.x_ready, bus.out_valid);
        end
        xs_random();
        exp_b = model(1);
        send_x(N, 1'b1);
        check_latency("b2b_second");
        get_result("b2b_second", exp_b);
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_random(0);
        xs_random();
        load_bank(0);
        send_x(N / 2, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp += 3;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.w_ready !== 1'b1)   begin n_err++; $display("FAIL midreset_w_ready: got %b want 1", bus.w_ready); end
        if (bus.x_ready !== 1'b0)   begin n_err++; $display("FAIL midreset_x_ready: got %b want 0", bus.x_ready); end
        reset = 1'b0;
        @(posedge clk); #1;
        run_case("midreset_reload", 0, 1'b0, model(0));
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < LANES; l++) bias[s][l] = 0;
        test_reset();
        test_ones();
        test_relu();
        test_saturate();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
